// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the audio capture to UDP streaming path.
package audio_pkg;

  localparam int unsigned PKT_WORDS_DEF  = 256;
  localparam int unsigned FIFO_DEPTH_DEF = 512;
  localparam int unsigned SAMPLE_W       = 32;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_SEND      = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo_512x32.sv
// Single-clock sample FIFO with registered read data and a registered word count.
module sync_fifo_512x32 #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             empty_c;
  logic             do_wr_c;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty_c = (wptr == rptr);
  assign do_wr_c = wr_en && !full_c;

  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr_c) wptr <= wptr + PW'(1);
      if (rd_en) begin
        rptr    <= rptr + PW'(1);
        rd_data <= mem[rptr[AW-1:0]];
      end
      case ({do_wr_c, rd_en})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) rd_en |-> !empty_c);

endmodule

// File: rtl/audio_cache_tx_ctrl.sv
// Buffers ADC samples and hands them to a UDP transmitter in fixed-size packets.
module audio_cache_tx_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned PKT_WORDS  = PKT_WORDS_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          eth_tx_clk,
  input  logic                          rst_n,
  input  logic                          adc_data_valid,
  input  logic [31:0]                   adc_data,
  output logic                          udp_tx_start_en,
  output logic [15:0]                   udp_tx_byte_num,
  input  logic                          udp_tx_req,
  output logic [31:0]                   udp_tx_data,
  input  logic                          udp_tx_done,
  output logic                          fifo_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = $clog2(PKT_WORDS) + 1;

  tx_state_e       state;
  tx_state_e       state_nxt;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   wcnt_nxt;
  logic            start_en_nxt;
  logic            pop_c;
  logic            fifo_full_c;

  assign udp_tx_byte_num = 16'(PKT_WORDS * 4);

  sync_fifo_512x32 #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (eth_tx_clk),
    .rst_n   (rst_n),
    .wr_en   (adc_data_valid),
    .wr_data (adc_data),
    .rd_en   (pop_c),
    .rd_data (udp_tx_data),
    .full_c  (fifo_full_c),
    .level   (fifo_level)
  );

  // State, registered outputs and the sticky drop flag.
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= TX_IDLE;
      wcnt            <= '0;
      udp_tx_start_en <= 1'b0;
      fifo_overflow   <= 1'b0;
    end else begin
      state           <= state_nxt;
      wcnt            <= wcnt_nxt;
      udp_tx_start_en <= start_en_nxt;
      fifo_overflow   <= fifo_overflow | (adc_data_valid & fifo_full_c);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:      if (fifo_level >= LW'(PKT_WORDS)) state_nxt = TX_START;
      TX_START:     state_nxt = TX_SEND;
      TX_SEND: begin
        // A done pulse during SEND aborts the packet.
        if (udp_tx_done)                               state_nxt = TX_IDLE;
        else if (pop_c && wcnt == CW'(PKT_WORDS - 1))  state_nxt = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: if (udp_tx_done) state_nxt = TX_IDLE;
      default:      state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    pop_c        = 1'b0;
    wcnt_nxt     = '0;
    start_en_nxt = 1'b0;
    if (state == TX_SEND) begin
      pop_c    = udp_tx_req && !udp_tx_done && (wcnt < CW'(PKT_WORDS));
      wcnt_nxt = wcnt + CW'(pop_c);
    end
    start_en_nxt = (state_nxt == TX_START);
  end

endmodule

// File: tb/tb_audio_cache_tx_ctrl.sv
// Randomised bench for audio_cache_tx_ctrl against a queue-based packetiser model.
module tb_audio_cache_tx_ctrl;

  localparam int PKT   = 256;
  localparam int DEPTH = 512;

  logic        eth_tx_clk = 1'b0;
  logic        rst_n;
  logic        adc_data_valid;
  logic [31:0] adc_data;
  logic        udp_tx_start_en;
  logic [15:0] udp_tx_byte_num;
  logic        udp_tx_req;
  logic [31:0] udp_tx_data;
  logic        udp_tx_done;
  logic        fifo_overflow;
  logic [9:0]  fifo_level;

  audio_cache_tx_ctrl dut (
    .eth_tx_clk      (eth_tx_clk),
    .rst_n           (rst_n),
    .adc_data_valid  (adc_data_valid),
    .adc_data        (adc_data),
    .udp_tx_start_en (udp_tx_start_en),
    .udp_tx_byte_num (udp_tx_byte_num),
    .udp_tx_req      (udp_tx_req),
    .udp_tx_data     (udp_tx_data),
    .udp_tx_done     (udp_tx_done),
    .fifo_overflow   (fifo_overflow),
    .fifo_level      (fifo_level)
  );

  always #5 eth_tx_clk = ~eth_tx_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: buffer contents as a queue plus packet phase (0 idle, 1 start, 2 send, 3 wait).
  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_ph, m_sent, m_starts;

  logic [31:0] dut_words[$];
  int          dut_starts, last_start_cyc;

  int          s_period, s_left;
  logic [31:0] s_val;

  bit          ag_en;
  int          ag_ph, ag_skip, ag_reqs, ag_min_reqs, ag_base, ag_cnt, ag_pct;

  task automatic model_reset();
    mq.delete();
    dut_words.delete();
    m_ovf = 0; m_ph = 0; m_sent = 0; m_starts = 0;
    dut_starts = 0; last_start_cyc = -1;
    s_period = 1; s_left = 0; s_val = '0;
    ag_en = 0; ag_ph = 0; ag_skip = 0; ag_reqs = 0; ag_min_reqs = 0; ag_base = 0; ag_cnt = 0; ag_pct = 100;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    adc_data_valid = 1'b0; adc_data = '0; udp_tx_req = 1'b0; udp_tx_done = 1'b0;
    repeat (3) begin @(posedge eth_tx_clk); #1; cyc++; end
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, advance the model by the packetiser rules, record DUT events.
  task automatic step(input bit v, input logic [31:0] dat, input bit r, input bit d);
    int pre;
    bit pop;
    logic [31:0] w;
    adc_data_valid = v; adc_data = dat; udp_tx_req = r; udp_tx_done = d;
    @(posedge eth_tx_clk); #1;
    cyc++;
    pre = mq.size();
    pop = 0;
    case (m_ph)
      0: if (pre >= PKT) m_ph = 1;
      1: begin m_ph = 2; m_sent = 0; end
      2: begin
        pop = r && !d && (m_sent < PKT);
        if (d) m_ph = 0;
        else if (pop && m_sent == PKT - 1) m_ph = 3;
        if (pop) m_sent++;
      end
      default: if (d) m_ph = 0;
    endcase
    if (pop) w = mq.pop_front();
    if (v) begin
      if (pre < DEPTH) mq.push_back(dat);
      else m_ovf = 1;
    end
    if (m_ph == 1) m_starts++;
    if (udp_tx_start_en) begin dut_starts++; last_start_cyc = cyc; end
    if (pop) dut_words.push_back(udp_tx_data);
  endtask

  // Runs strobe generator and UDP transmitter agent for up to n cycles.
  task automatic run(input int n, input int stop_words);
    for (int i = 0; i < n; i++) begin
      bit v, r, d;
      logic [31:0] dat;
      v = 0; r = 0; d = 0; dat = $urandom;
      if (s_left > 0 && (cyc % s_period) == 0) begin
        v = 1; dat = s_val; s_val = s_val + 32'd1; s_left--;
      end
      if (ag_en) begin
        if (ag_ph == 1) begin
          if (ag_skip > 0) ag_skip--;
          else r = ($urandom_range(99) < ag_pct);
        end else if (ag_ph == 2) begin
          if (ag_cnt == 0) begin d = 1; ag_ph = 0; end
          else ag_cnt--;
        end
      end
      if (r) ag_reqs++;
      step(v, dat, r, d);
      if (ag_en) begin
        if (udp_tx_start_en) begin
          ag_ph = 1; ag_skip = 1; ag_reqs = 0; ag_base = dut_words.size();
        end else if (ag_ph == 1 && dut_words.size() - ag_base >= PKT && ag_reqs >= ag_min_reqs) begin
          ag_ph = 2; ag_cnt = 2;
        end
      end
      if (stop_words > 0 && dut_words.size() >= stop_words) break;
    end
    adc_data_valid = 0; udp_tx_req = 0; udp_tx_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adc_data_valid = 1'(($urandom));
      adc_data = $urandom; udp_tx_req = 1'($urandom); udp_tx_done = 1'($urandom);
      @(posedge eth_tx_clk); #1; cyc++;
    end
    checks++; if (udp_tx_start_en !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", udp_tx_start_en); end
    checks++; if (udp_tx_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", udp_tx_data); end
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", fifo_overflow); end
    checks++; if (fifo_level !== 10'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (udp_tx_byte_num !== 16'd1024) begin errors++; $display("FAIL byte_num got %0d want 1024", udp_tx_byte_num); end
    apply_reset();
  endtask

  task automatic test_basic_packet();
    int bad;
    apply_reset();
    s_left = PKT; s_val = 32'd0; ag_en = 1; ag_pct = 100;
    run(600, 0);
    checks++; if (dut_starts !== 1) begin errors++; $display("FAIL basic_starts got %0d want 1", dut_starts); end
    checks++; if (udp_tx_byte_num !== 16'd1024) begin errors++; $display("FAIL basic_byte_num got %0d want 1024", udp_tx_byte_num); end
    checks++; if (dut_words.size() !== PKT) begin errors++; $display("FAIL basic_count got %0d want %0d", dut_words.size(), PKT); end
    bad = -1;
    foreach (dut_words[i]) if (bad < 0 && dut_words[i] !== 32'(i)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL basic_data idx %0d got %h want %h", bad, dut_words[bad], 32'(bad)); end
    checks++; if (fifo_level !== 10'd0) begin errors++; $display("FAIL basic_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_threshold();
    int c0;
    apply_reset();
    s_left = PKT - 1; s_val = $urandom;
    run(PKT + 4, 0);
    checks++; if (dut_starts !== 0) begin errors++; $display("FAIL thr_early_start got %0d want 0", dut_starts); end
    s_left = 1;
    c0 = cyc;
    run(6, 0);
    checks++; if (last_start_cyc !== c0 + 2) begin errors++; $display("FAIL thr_latency got cycle %0d want %0d", last_start_cyc, c0 + 2); end
    checks++; if (dut_starts !== 1) begin errors++; $display("FAIL thr_starts got %0d want 1", dut_starts); end
  endtask

  task automatic test_overflow();
    logic [31:0] base;
    int bad;
    apply_reset();
    base = $urandom; s_val = base; s_left = DEPTH;
    run(DEPTH + 4, 0);
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b want 0", fifo_overflow); end
    s_left = 8;
    run(10, 0);
    checks++; if (fifo_level !== 10'(DEPTH)) begin errors++; $display("FAIL ovf_level got %0d want %0d", fifo_level, DEPTH); end
    checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", fifo_overflow); end
    ag_en = 1; ag_ph = 1; ag_skip = 0; ag_reqs = 0; ag_base = 0; ag_pct = 80;
    run(1500, 0);
    checks++; if (dut_words.size() !== DEPTH) begin errors++; $display("FAIL ovf_drain_count got %0d want %0d", dut_words.size(), DEPTH); end
    bad = -1;
    foreach (dut_words[i]) if (bad < 0 && dut_words[i] !== base + 32'(i)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL ovf_retained idx %0d got %h want %h", bad, dut_words[bad], base + 32'(bad)); end
    checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", fifo_overflow); end
  endtask

  task automatic test_stream_during_send();
    logic [31:0] base;
    int bad, sent;
    apply_reset();
    base = $urandom; s_val = base; s_period = 4; s_left = 800; ag_en = 1; ag_pct = 75;
    run(2800, 0);
    sent = 800 - s_left;
    checks++; if (dut_starts < 2 || dut_starts !== m_starts) begin errors++; $display("FAIL stream_starts got %0d want %0d (>=2)", dut_starts, m_starts); end
    checks++; if (dut_words.size() < 2 * PKT) begin errors++; $display("FAIL stream_words got %0d want >= %0d", dut_words.size(), 2 * PKT); end
    bad = -1;
    foreach (dut_words[i]) if (bad < 0 && dut_words[i] !== base + 32'(i)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL stream_continuity idx %0d got %h want %h", bad, dut_words[bad], base + 32'(bad)); end
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b want 0", fifo_overflow); end
    checks++; if (int'(fifo_level) !== sent - dut_words.size()) begin errors++; $display("FAIL stream_level got %0d want %0d", fifo_level, sent - dut_words.size()); end
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] b1, b2;
    int bad;
    apply_reset();
    b1 = $urandom; s_val = b1; s_left = PKT; ag_en = 1; ag_pct = 100;
    run(700, 100);
    checks++; if (dut_words.size() !== 100 || dut_words[99] !== b1 + 32'd99) begin errors++; $display("FAIL mid_prefix got %0d words want 100"
      , dut_words.size()); end
    rst_n = 1'b0; adc_data_valid = 0; udp_tx_req = 0;
    #2;
    checks++; if (udp_tx_start_en !== 1'b0 || udp_tx_data !== 32'd0 || fifo_overflow !== 1'b0) begin
      errors++; $display("FAIL mid_outputs got start %b data %h ovf %b want 0 0 0", udp_tx_start_en, udp_tx_data, fifo_overflow); end
    checks++; if (fifo_level !== 10'd0) begin errors++; $display("FAIL mid_level got %0d want 0", fifo_level); end
    @(posedge eth_tx_clk); #1; cyc++;
    rst_n = 1'b1;
    model_reset();
    b2 = $urandom; s_val = b2; s_left = PKT; ag_en = 1; ag_pct = 90;
    run(800, 0);
    checks++; if (dut_words.size() !== PKT || dut_starts !== 1) begin errors++; $display("FAIL mid_fresh got %0d words %0d starts want %0d 1", dut_words.size(), dut_starts, PKT); end
    bad = -1;
    foreach (dut_words[i]) if (bad < 0 && dut_words[i] !== b2 + 32'(i)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL mid_fresh_data idx %0d got %h want %h", bad, dut_words[bad], b2 + 32'(bad)); end
  endtask

  task automatic test_excess_requests();
    logic [31:0] base;
    int bad;
    apply_reset();
    base = $urandom; s_val = base; s_left = 300; ag_en = 1; ag_pct = 100; ag_min_reqs = 300;
    run(1000, 0);
    checks++; if (dut_words.size() !== PKT) begin errors++; $display("FAIL excess_pops got %0d want %0d", dut_words.size(), PKT); end
    checks++; if (fifo_level !== 10'd44) begin errors++; $display("FAIL excess_level got %0d want 44", fifo_level); end
    bad = -1;
    foreach (dut_words[i]) if (bad < 0 && dut_words[i] !== base + 32'(i)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL excess_data idx %0d got %h want %h", bad, dut_words[bad], base + 32'(bad)); end
    checks++; if (dut_starts !== 1) begin errors++; $display("FAIL excess_starts got %0d want 1", dut_starts); end
  endtask

  initial begin
    rst_n = 1'b0;
    adc_data_valid = 0; adc_data = '0; udp_tx_req = 0; udp_tx_done = 0;
    model_reset();
    test_reset();
    test_basic_packet();
    test_threshold();
    test_overflow();
    test_stream_during_send();
    test_reset_mid_packet();
    test_excess_requests();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
